fetch_unit: RTL

- Initiator side of the instruction-memory read interface.
- Holds the fetch PC and drives the word-aligned byte address to the memory. The memory returns a big-endian 32-bit word one clock later.
- Buffers returned words in a small queue and presents them to decode over a valid/ready handshake.
- Supports branch redirect with flush. Stops fetching past the end of the instruction store.

---
 rtl/fetch_unit.sv | 103 ++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues word-aligned reads to the instruction store,
// queues the returned words and hands them to decode over a valid/ready handshake.
module fetch_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter int          MEM_BYTES = 72,
    parameter int          DEPTH     = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] mem_addr,
    input  logic [31:0] mem_instr,
    output logic        instr_valid,
    output logic [31:0] instr_out,
    output logic [15:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic        halted
);

    localparam int          PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          CW      = $clog2(DEPTH + 1);
    localparam logic [15:0] LAST_PC = 16'(MEM_BYTES - 4);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);
    localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);

    logic [15:0]   r_fetch_pc;
    logic          r_pending;
    logic [15:0]   r_pending_pc;
    logic [31:0]   r_q_instr [DEPTH];
    logic [15:0]   r_q_pc    [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic          w_in_range;
    logic          w_pop;
    logic          w_push;
    logic          w_issue;
    logic [CW:0]   w_credit;
    logic          w_unused_redirect_lsbs;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST_IDX) ? '0 : p + 1'b1;
    endfunction

    assign w_in_range = (r_fetch_pc <= LAST_PC);
    assign w_pop      = instr_valid & instr_ready & ~redirect_valid;
    assign w_push     = r_pending & ~redirect_valid;
    // Credit counts the in-flight word so a response always finds a free slot.
    assign w_credit   = {1'b0, r_count} + (CW + 1)'(r_pending) - (CW + 1)'(w_pop);
    assign w_issue    = ~redirect_valid & w_in_range & (w_credit < DEPTH_C);

    assign w_unused_redirect_lsbs = &{1'b1, redirect_pc[1:0]};

    assign mem_addr    = r_fetch_pc;
    assign instr_valid = (r_count != '0);
    assign instr_out   = instr_valid ? r_q_instr[r_head] : '0;
    assign instr_pc    = instr_valid ? r_q_pc[r_head]    : '0;
    assign halted      = ~w_in_range & (r_count == '0) & ~r_pending;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc   <= RESET_PC;
            r_pending    <= 1'b0;
            r_pending_pc <= '0;
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
        end else if (redirect_valid) begin
            r_fetch_pc   <= {redirect_pc[15:2], 2'b00};
            r_pending    <= 1'b0;
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
        end else begin
            r_pending <= w_issue;
            if (w_issue) begin
                r_fetch_pc   <= r_fetch_pc + 16'd4;
                r_pending_pc <= r_fetch_pc;
            end
            if (w_push) r_tail <= next_ptr(r_tail);
            if (w_pop)  r_head <= next_ptr(r_head);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: queue storage is not reset; the outputs are masked by instr_valid,
    // so stale contents are never observable.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_instr[r_tail] <= mem_instr;
            r_q_pc[r_tail]    <= r_pending_pc;
        end
    end

endmodule
